// File: rtl/spi_master.sv
// rtl/spi_master.sv - SPI mode-0 initiator issuing one 16-bit address/rw/data frame per request
//
// Purpose:
//   Drives a single 16-bit mode-0 SPI frame against the SPI memory responder.
//   Frame layout on mosi, MSB first: {addr[6:0], rw, data[7:0]}.
//   For reads the data field is sent as zeros. The byte returned on miso
//   during the last eight bit slots is captured and presented on rdData.
//   sclk and cs are generated internally from clk.
//
// Parameters:
//   HALF_PERIOD - clk cycles per sclk half-period (>= 1)
//
// Ports:
//   clk     in   system clock, all state updates on the rising edge
//   reset   in   synchronous active-high reset
//   start   in   transaction request, accepted only while busy=0
//   rw      in   1 = read, 0 = write, sampled at acceptance
//   addr    in   7-bit memory address, sampled at acceptance
//   wrData  in   write data, sampled at acceptance, ignored for reads
//   busy    out  high from acceptance until the done cycle
//   done    out  one-cycle completion pulse
//   rdData  out  byte captured by the last completed read
//   sclk    out  SPI clock, idles low
//   cs      out  active-low chip select, idles high
//   mosi    out  serial data to the responder
//   miso    in   serial data from the responder

module spi_master #(
    parameter int HALF_PERIOD = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] wrData,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdData,
    output logic       sclk,
    output logic       cs,
    output logic       mosi,
    input  logic       miso
);

    localparam int CW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        SHIFT_LOW,
        SHIFT_HIGH,
        HOLD
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;        // cycles spent in the current half-period
    logic [3:0]    bit_idx;    // frame bit being transferred, 0 = frame[15]
    logic [15:0]   frame;      // outgoing frame, shifted left after each bit
    logic [7:0]    rx;         // miso capture register, MSB first
    logic          is_read;
    logic          phase_end;

    // Every timed phase (lead, low, high, hold) lasts exactly HALF_PERIOD cycles.
    assign phase_end = (cnt == CW'(HALF_PERIOD - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            frame   <= '0;
            rx      <= '0;
            is_read <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            rdData  <= '0;
            sclk    <= 1'b0;
            cs      <= 1'b1;
            mosi    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        frame   <= {addr, rw, (rw ? 8'h00 : wrData)};
                        is_read <= rw;
                        mosi    <= addr[6];
                        busy    <= 1'b1;
                        cs      <= 1'b0;
                        sclk    <= 1'b0;
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= LEAD;
                    end
                end

                // LEAD plus the first SHIFT_LOW give the responder a full
                // sclk period of setup on bit 15 after cs falls.
                LEAD: begin
                    if (phase_end) begin
                        cnt   <= '0;
                        state <= SHIFT_LOW;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                SHIFT_LOW: begin
                    if (phase_end) begin
                        cnt   <= '0;
                        sclk  <= 1'b1;
                        state <= SHIFT_HIGH;
                        // Only the data half of the frame carries read data.
                        if (bit_idx[3]) begin
                            rx <= {rx[6:0], miso};
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                SHIFT_HIGH: begin
                    if (phase_end) begin
                        cnt  <= '0;
                        sclk <= 1'b0;
                        if (bit_idx == 4'd15) begin
                            mosi  <= 1'b0;
                            state <= HOLD;
                        end else begin
                            // mosi changes only on the falling edge so it is
                            // stable across the whole high phase.
                            bit_idx <= bit_idx + 1'b1;
                            frame   <= {frame[14:0], 1'b0};
                            mosi    <= frame[14];
                            state   <= SHIFT_LOW;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                HOLD: begin
                    if (phase_end) begin
                        cnt   <= '0;
                        cs    <= 1'b1;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                        if (is_read) begin
                            rdData <= rx;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
